cp0_ctrl: RTL and testbench

Parametrised coprocessor-0 for the pipelined MIPS core. Holds SR, Cause, EPC and PRId, plus optional Count/Compare, for the exception/interrupt path.
- Sits at the M stage. Receives the exception code and PC of the instruction in M, plus the hardware interrupt lines.
- Raises a one-cycle take request to the pipeline controller and supplies EPC for eret.

---
 rtl/cp0_pkg.sv | 42 ++++
 rtl/cp0_timer.sv | 37 +++
 rtl/cp0_ctrl.sv | 138 +++++++++++++
 tb/tb_cp0_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_pkg
// Purpose  : Shared CP0 register numbers, SR/Cause bit positions, exception
//            codes and the EPC alignment helper.
// Revision : 1.0  initial release
// ============================================================================
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] epc_align(input logic [31:0] value, input bit en);
        return en ? {value[31:2], 2'b00} : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module   : cp0_timer
// Purpose  : Count/Compare timer with sticky TI flag; only built when
//            CP0_TIMER_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= 32'd0;
            compare <= 32'hFFFF_FFFF;
            ti      <= 1'b0;
        end else begin
            count <= count_we ? wr_data : count + 32'd1;
            // A Compare write acknowledges the timer and wins over a match
            if (compare_we) begin
                compare <= wr_data;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_ctrl
// Purpose  : Coprocessor-0 (SR, Cause, EPC, PRId) at the M stage; optional
//            Count/Compare timer enabled by defining CP0_TIMER_EN.
// Revision : 1.0  initial release
// ============================================================================
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h1234_5678,
    parameter bit          EPC_ALIGN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rd_addr,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 we,
    input  logic [31:0]          pc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 eret,
    output logic                 take,
    output logic [31:0]          epc_out,
    output logic [31:0]          rd_data
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_r;
    logic [31:0] epc;

    logic [5:0]  pend;
    logic        ti;
    logic        int_req;
    logic        exc_req;
    logic        wr_ok;
    logic [31:0] epc_next;

    // mtc0 is squashed in the cycle an exception or interrupt is taken
    assign wr_ok = we & ~take;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (wr_ok && (wr_addr == CP0_COUNT)),
        .compare_we (wr_ok && (wr_addr == CP0_COMPARE)),
        .wr_data    (wr_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign ti = 1'b0;
`endif

    always_comb begin
        pend                = '0;
        pend[NUM_HWINT-1:0] = hw_int;
        pend[5]             = pend[5] | ti;
    end

    assign int_req  = (|(pend & im)) & ie & ~exl;
    assign exc_req  = (exc_code != EXC_INT) & ~exl;
    assign take     = int_req | exc_req;
    assign epc_next = epc_align(bd_in ? pc - 32'd4 : pc, EPC_ALIGN);
    assign epc_out  = take ? epc_next : epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            im    <= '0;
            exl   <= 1'b0;
            ie    <= 1'b0;
            bd    <= 1'b0;
            ip    <= '0;
            exc_r <= EXC_INT;
            epc   <= 32'd0;
        end else begin
            ip <= pend;
            if (take) begin
                exl   <= 1'b1;
                bd    <= bd_in;
                epc   <= epc_next;
                exc_r <= int_req ? EXC_INT : exc_code;
            end else begin
                if (we && (wr_addr == CP0_SR)) begin
                    im  <= wr_data[SR_IM_HI:SR_IM_LO];
                    exl <= wr_data[SR_EXL];
                    ie  <= wr_data[SR_IE];
                end
                if (we && (wr_addr == CP0_EPC)) begin
                    epc <= epc_align(wr_data, EPC_ALIGN);
                end
                if (eret) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CP0_SR: begin
                rd_data[SR_IM_HI:SR_IM_LO] = im;
                rd_data[SR_EXL]            = exl;
                rd_data[SR_IE]             = ie;
            end
            CP0_CAUSE: begin
                rd_data[CAUSE_BD]                   = bd;
                rd_data[CAUSE_TI]                   = ti;
                rd_data[CAUSE_IP_HI:CAUSE_IP_LO]    = ip;
                rd_data[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc_r;
            end
            CP0_EPC:     rd_data = epc;
            CP0_PRID:    rd_data = PRID_VAL;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   rd_data = count;
            CP0_COMPARE: rd_data = compare;
`else
            CP0_COUNT, CP0_COMPARE: rd_data = '0;
`endif
            default:     rd_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_ctrl
// Purpose  : Self-checking bench for cp0_ctrl: directed literal checks plus
//            randomized traffic against a word-level CP0 model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cp0_ctrl;
    import cp0_pkg::*;

    localparam int          NUM_HWINT = 6;
    localparam logic [31:0] PRID_VAL  = 32'h1234_5678;
    localparam bit          EPC_ALIGN = 1'b1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [4:0]           rd_addr, wr_addr;
    logic [31:0]          wr_data;
    logic                 we;
    logic [31:0]          pc;
    logic                 bd_in;
    logic [4:0]           exc_code;
    logic [NUM_HWINT-1:0] hw_int;
    logic                 eret;
    logic                 take;
    logic [31:0]          epc_out, rd_data;

    int compared   = 0;
    int mismatched = 0;

    // Model state as architectural register words
    logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
    logic        m_ti;
    logic        s_take;
    logic [31:0] s_epc, s_rd;

    always #5 clk = ~clk;

    cp0_ctrl #(
        .NUM_HWINT (NUM_HWINT),
        .PRID_VAL  (PRID_VAL),
        .EPC_ALIGN (EPC_ALIGN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .we       (we),
        .pc       (pc),
        .bd_in    (bd_in),
        .exc_code (exc_code),
        .hw_int   (hw_int),
        .eret     (eret),
        .take     (take),
        .epc_out  (epc_out),
        .rd_data  (rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12: return m_sr;
            5'd13: return m_cause | {1'b0, m_ti, 30'd0};
            5'd14: return m_epc;
            5'd15: return PRID_VAL;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        rd_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'd0; we = 1'b0;
        pc = 32'd0; bd_in = 1'b0; exc_code = 5'd0; hw_int = '0; eret = 1'b0;
    endtask

    // Called 1ns after a rising edge with inputs driven; samples, checks,
    // advances the model across the next edge and returns 1ns after it.
    task automatic cycle();
        logic [5:0]  pend;
        logic        ireq, ereq, tk, n_ti;
        logic [31:0] en, n_sr, n_cause, n_epc, n_count, n_compare;
        #3;
        s_take = take; s_epc = epc_out; s_rd = rd_data;
        pend    = 6'(hw_int);
        pend[5] = pend[5] | m_ti;
        ireq = ((pend & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        ereq = (exc_code != 5'd0) && !m_sr[1];
        tk   = ireq || ereq;
        en   = bd_in ? pc - 32'd4 : pc;
        if (EPC_ALIGN) en[1:0] = 2'b00;
        if (!reset) begin
            check("take", {31'd0, s_take}, {31'd0, tk});
            check("epc_out", s_epc, tk ? en : m_epc);
            check("rd_data", s_rd, model_read(rd_addr));
        end
        n_sr = m_sr; n_epc = m_epc; n_compare = m_compare;
        n_count = m_count + 32'd1;
        n_ti    = m_ti || (m_count == m_compare);
        n_cause = {m_cause[31], 1'b0, 14'd0, pend, 3'd0, m_cause[6:2], 2'b00};
        if (tk) begin
            n_sr[1]      = 1'b1;
            n_cause[31]  = bd_in;
            n_cause[6:2] = ireq ? 5'd0 : exc_code;
            n_epc        = en;
        end else begin
            if (we) begin
                case (wr_addr)
                    5'd12: n_sr = wr_data & 32'h0000_FC03;
                    5'd14: n_epc = EPC_ALIGN ? {wr_data[31:2], 2'b00} : wr_data;
                    5'd9:  n_count = wr_data;
                    5'd11: begin n_compare = wr_data; n_ti = 1'b0; end
                    default: ;
                endcase
            end
            if (eret) n_sr[1] = 1'b0;
        end
`ifndef CP0_TIMER_EN
        n_ti = 1'b0;
`endif
        if (reset) begin
            n_sr = 32'd0; n_cause = 32'd0; n_epc = 32'd0;
            n_count = 32'd0; n_compare = 32'hFFFF_FFFF; n_ti = 1'b0;
        end
        @(posedge clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        m_count = n_count; m_compare = n_compare; m_ti = n_ti;
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); we = 1'b1; wr_addr = a; wr_data = d; cycle();
    endtask

    task automatic mfc0(input logic [4:0] a);
        idle(); rd_addr = a; cycle();
    endtask

    initial begin
        m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = '1; m_ti = 0;
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        repeat (3) cycle();
        reset = 1'b0;

        // Reset values
        mfc0(5'd12); check("reset_sr", s_rd, 32'd0); check("reset_take", {31'd0, s_take}, 32'd0);
        mfc0(5'd13); check("reset_cause", s_rd, 32'd0);
        mfc0(5'd14); check("reset_epc", s_rd, 32'd0);
        mfc0(5'd15); check("prid", s_rd, 32'h1234_5678);

        // Interrupt on hw_int[2]
        mtc0(5'd12, 32'h0000_FC01);
        idle(); hw_int = 6'b000100; pc = 32'h0000_2000; rd_addr = 5'd12; cycle();
        check("int_take", {31'd0, s_take}, 32'd1);
        check("int_epc_fwd", s_epc, 32'h0000_2000);
        check("sr_before", s_rd, 32'h0000_FC01);
        mfc0(5'd13); check("int_cause", s_rd, 32'h0000_1000);
        mfc0(5'd12); check("int_exl", s_rd, 32'h0000_FC03);
        idle(); eret = 1'b1; cycle();
        mfc0(5'd12); check("eret_exl", s_rd, 32'h0000_FC01);

        // Overflow in a delay slot, then a masked second exception
        idle(); exc_code = EXC_OV; bd_in = 1'b1; pc = 32'h0000_3010; cycle();
        check("ov_take", {31'd0, s_take}, 32'd1);
        check("ov_epc_fwd", s_epc, 32'h0000_300C);
        idle(); exc_code = EXC_ADEL; rd_addr = 5'd14; cycle();
        check("exl_blocks", {31'd0, s_take}, 32'd0);
        check("ov_epc", s_rd, 32'h0000_300C);
        mfc0(5'd13); check("ov_cause", s_rd, 32'h8000_0030);

        // eret together with take: take wins
        idle(); eret = 1'b1; cycle();
        idle(); eret = 1'b1; exc_code = EXC_ADES; cycle();
        check("eret_take", {31'd0, s_take}, 32'd1);
        mfc0(5'd12); check("eret_take_exl", s_rd, 32'h0000_FC03);
        idle(); eret = 1'b1; cycle();

        // Interrupt beats exception; concurrent mtc0 dropped
        idle(); hw_int = 6'b000001; exc_code = EXC_RI; we = 1'b1; wr_addr = 5'd12; cycle();
        check("prio_take", {31'd0, s_take}, 32'd1);
        mfc0(5'd13); check("prio_cause", s_rd, 32'h0000_0400);
        mfc0(5'd12); check("mtc0_dropped", s_rd, 32'h0000_FC03);
        idle(); eret = 1'b1; cycle();

        // EPC alignment and read-only Cause
        mtc0(5'd14, 32'h0000_3007);
        mfc0(5'd14); check("epc_align", s_rd, 32'h0000_3004);
        mtc0(5'd13, 32'hFFFF_FFFF);
        mfc0(5'd13); check("cause_ro", s_rd, 32'h0000_0000);

`ifdef CP0_TIMER_EN
        begin
            int lat = -1;
            mtc0(5'd9, 32'd0);
            mtc0(5'd11, 32'd5);
            for (int i = 0; i < 12 && lat < 0; i++) begin
                idle(); cycle();
                if (s_take) lat = i;
            end
            check("timer_latency", 32'(lat), 32'd5);
            idle(); rd_addr = 5'd13; we = 1'b1; wr_addr = 5'd11; wr_data = 32'hFFFF_FFF0; cycle();
            check("ti_set", s_rd & 32'h4000_0000, 32'h4000_0000);
            mfc0(5'd13); check("ti_clear", s_rd & 32'h4000_0000, 32'd0);
            idle(); eret = 1'b1; cycle();
        end
`else
        mtc0(5'd9, 32'h55);
        mfc0(5'd9); check("count_absent", s_rd, 32'd0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: wr_addr = 5'd9;
                1: wr_addr = 5'd11;
                2, 3: wr_addr = 5'd12;
                4: wr_addr = 5'd13;
                5: wr_addr = 5'd14;
                6: wr_addr = 5'd15;
                default: wr_addr = 5'($urandom);
            endcase
            wr_data = $urandom;
            if (wr_addr == 5'd12 && $urandom_range(0, 3) != 0) wr_data[1:0] = 2'b01;
            if (wr_addr == 5'd11 && $urandom_range(0, 1) == 0) wr_data = m_count + $urandom_range(1, 20);
            rd_addr  = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(8, 15));
            pc       = $urandom;
            bd_in    = 1'($urandom_range(0, 1));
            exc_code = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            hw_int   = ($urandom_range(0, 4) == 0) ? NUM_HWINT'($urandom) : '0;
            eret     = !we && ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
